// File: rtl/hamming_serializer_pkg.sv
// Shared definitions for the Hamming codec slice: codeword geometry and the
// serializer frame FSM state encoding.
package hamming_serializer_pkg;

    localparam int unsigned HAM_CW_W       = 12;
    localparam int unsigned HAM_DATA_W     = 8;
    localparam int unsigned HAM_FRAME_BITS = HAM_CW_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ham_state_e;

endpackage

// File: rtl/hamming_bit_timer.sv
// Line-bit timer: free-running divider that pulses tick on the last cycle of
// every CLK_DIV-cycle bit period; clear holds it at the start of a period.
module hamming_bit_timer #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned      CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/hamming_serializer.sv
// Serial transmitter for Hamming codewords: start bit, CW_W data bits LSB
// first, stop bit, each held CLK_DIV cycles; valid/ready input handshake.
module hamming_serializer
    import hamming_serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned CW_W    = HAM_CW_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW_W-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            tx,
    output logic            busy
);

    localparam int unsigned      BIT_W    = $clog2(CW_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CW_W - 1);

    ham_state_e        state_q, state_d;
    logic [CW_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              tick;
    logic              clear;

    hamming_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    // The timer restarts its period on the transfer edge, so START lasts
    // exactly CLK_DIV cycles from the cycle tx first goes low.
    assign clear   = (state_q == ST_IDLE);
    assign s_ready = rst && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_valid && s_ready) begin
                    shift_d   = s_data;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[CW_W-1:1]};
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[CW_W-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
